// File: rtl/ifm_pingpong_bank.sv
// Double-buffered IFM store: the producer fills one bank while the conv layer reads the other.
// Latency: reads are registered (1 cycle); start_to_next pulses on the 2nd edge after the filling wr_done.
// Backpressure: wr_ready is low while the write bank is still full; writes and wr_done are dropped then.
module ifm_pingpong_bank #(
    parameter int DATA_WIDTH       = 32,
    parameter int IFM_SIZE         = 5,
    parameter int IFM_DEPTH        = 16,
    parameter int NUMBER_OF_UNITS  = 3,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE),
    parameter int MAP_BITS         = $clog2(IFM_DEPTH),
    parameter int SEL_BITS         = $clog2(IFM_DEPTH/NUMBER_OF_UNITS+1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_enable,
    input  logic [MAP_BITS-1:0]         wr_map,
    input  logic [ADDRESS_SIZE_IFM-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        wr_done,
    output logic                        wr_ready,
    output logic                        start_to_next,
    input  logic                        end_from_next,
    input  logic                        ifm_enable_read,
    input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read,
    input  logic [SEL_BITS-1:0]         ifm_sel,
    output logic [DATA_WIDTH-1:0]       data_out1,
    output logic [DATA_WIDTH-1:0]       data_out2,
    output logic [DATA_WIDTH-1:0]       data_out3
);
    localparam int MAP_WORDS  = IFM_SIZE*IFM_SIZE;
    localparam int BANK_WORDS = IFM_DEPTH*MAP_WORDS;
    localparam int MEM_WORDS  = 2*BANK_WORDS;
    localparam int MEM_AW     = $clog2(MEM_WORDS);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic       wb;
    logic       rb;
    logic [1:0] full;
    logic       busy;
    logic [1:0] full_nxt;
    logic       done_fire;
    logic       end_fire;
    logic       start_fire;
    logic       wr_fire;

    function automatic logic [MEM_AW-1:0] mem_idx(input logic bank, input int map, input int addr);
        int flat;
        flat = (bank ? BANK_WORDS : 0) + map*MAP_WORDS + addr;
        return flat[MEM_AW-1:0];
    endfunction

    assign wr_ready   = !full[wb];
    assign done_fire  = wr_done && wr_ready;
    assign end_fire   = end_from_next && busy;
    assign start_fire = full[rb] && !busy && !start_to_next;

    // wb and rb never point at the same bank when both events fire, so the two updates never collide.
    always_comb begin
        full_nxt = full;
        if (done_fire) full_nxt[wb] = 1'b1;
        if (end_fire)  full_nxt[rb] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb            <= 1'b0;
            rb            <= 1'b0;
            full          <= 2'b00;
            busy          <= 1'b0;
            start_to_next <= 1'b0;
        end else begin
            full          <= full_nxt;
            start_to_next <= start_fire;
            if (done_fire) wb <= ~wb;
            if (end_fire) begin
                rb   <= ~rb;
                busy <= 1'b0;
            end else if (start_fire) begin
                busy <= 1'b1;
            end
        end
    end

    assign wr_fire = wr_enable && wr_ready && !reset
                  && (int'(wr_address) < MAP_WORDS) && (int'(wr_map) < IFM_DEPTH);

    always_ff @(posedge clk) begin
        if (wr_fire) mem[mem_idx(wb, int'(wr_map), int'(wr_address))] <= wr_data;
    end

    // Unit k of group g reads map g*NUMBER_OF_UNITS+k; maps past the bank depth read as zero.
    int                    rd_map [NUMBER_OF_UNITS];
    logic                  rd_ok  [NUMBER_OF_UNITS];
    logic [MEM_AW-1:0]     rd_idx [NUMBER_OF_UNITS];
    logic [DATA_WIDTH-1:0] rd_dat [NUMBER_OF_UNITS];

    always_comb begin
        for (int k = 0; k < NUMBER_OF_UNITS; k++) begin
            rd_map[k] = int'(ifm_sel)*NUMBER_OF_UNITS + k;
            rd_ok[k]  = (rd_map[k] < IFM_DEPTH) && (int'(ifm_address_read) < MAP_WORDS);
            rd_idx[k] = mem_idx(rb, rd_map[k], int'(ifm_address_read));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUMBER_OF_UNITS; k++) rd_dat[k] <= '0;
        end else if (ifm_enable_read) begin
            for (int k = 0; k < NUMBER_OF_UNITS; k++) begin
                rd_dat[k] <= rd_ok[k] ? mem[rd_idx[k]] : '0;
            end
        end
    end

    assign data_out1 = rd_dat[0];
    assign data_out2 = rd_dat[1];
    assign data_out3 = rd_dat[2];

endmodule

// File: tb/tb_ifm_pingpong_bank.sv
// Directed bench for ifm_pingpong_bank: bank filling, start/end handshake, reads, blocked writes, resets.
module tb_ifm_pingpong_bank;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MB = 4;
    localparam int SB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_enable;
    logic [MB-1:0] wr_map;
    logic [AW-1:0] wr_address;
    logic [DW-1:0] wr_data;
    logic          wr_done;
    logic          wr_ready;
    logic          start_to_next;
    logic          end_from_next;
    logic          ifm_enable_read;
    logic [AW-1:0] ifm_address_read;
    logic [SB-1:0] ifm_sel;
    logic [DW-1:0] data_out1;
    logic [DW-1:0] data_out2;
    logic [DW-1:0] data_out3;

    int n_tests   = 0;
    int n_fail    = 0;
    int start_cnt = 0;
    int base;

    ifm_pingpong_bank dut (
        .clk              (clk),
        .reset            (reset),
        .wr_enable        (wr_enable),
        .wr_map           (wr_map),
        .wr_address       (wr_address),
        .wr_data          (wr_data),
        .wr_done          (wr_done),
        .wr_ready         (wr_ready),
        .start_to_next    (start_to_next),
        .end_from_next    (end_from_next),
        .ifm_enable_read  (ifm_enable_read),
        .ifm_address_read (ifm_address_read),
        .ifm_sel          (ifm_sel),
        .data_out1        (data_out1),
        .data_out2        (data_out2),
        .data_out3        (data_out3)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_to_next === 1'b1) start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input int base_val);
        for (int m = 0; m < 16; m++) begin
            for (int a = 0; a < 25; a++) begin
                wr_enable  = 1'b1;
                wr_map     = MB'(m);
                wr_address = AW'(a);
                wr_data    = DW'(base_val + m*100 + a);
                tick(1);
            end
        end
        wr_enable = 1'b0;
    endtask

    task automatic pulse_done();
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
    endtask

    task automatic pulse_end();
        end_from_next = 1'b1;
        tick(1);
        end_from_next = 1'b0;
    endtask

    task automatic rd(input int g, input int a);
        ifm_enable_read  = 1'b1;
        ifm_sel          = SB'(g);
        ifm_address_read = AW'(a);
        tick(1);
        ifm_enable_read  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int e1, input int e2, input int e3);
        check({tag, "_d1"}, data_out1, e1);
        check({tag, "_d2"}, data_out2, e2);
        check({tag, "_d3"}, data_out3, e3);
    endtask

    initial begin
        // reset held for two edges with every input active
        reset            = 1'b1;
        wr_enable        = 1'b1;
        wr_map           = 4'd2;
        wr_address       = 5'd3;
        wr_data          = 32'hFFFF_0000;
        wr_done          = 1'b1;
        end_from_next    = 1'b1;
        ifm_enable_read  = 1'b1;
        ifm_sel          = 3'd0;
        ifm_address_read = 5'd3;
        tick(2);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_start", start_to_next, 0);
        chk_out("rst", 0, 0, 0);

        reset           = 1'b0;
        wr_enable       = 1'b0;
        wr_done         = 1'b0;
        end_from_next   = 1'b0;
        ifm_enable_read = 1'b0;
        base = start_cnt;
        pulse_end();
        tick(9);
        check("idle_no_start", start_cnt - base, 0);
        check("idle_wr_ready", wr_ready, 1);

        // fill bank0 and hand it over
        fill(0);
        check("fill_wr_ready", wr_ready, 1);
        base = start_cnt;
        pulse_done();
        check("done_start_e0", start_to_next, 0);
        check("done_wr_ready", wr_ready, 1);
        tick(1);
        check("done_start_e1", start_to_next, 1);
        tick(1);
        check("done_start_e2", start_to_next, 0);
        tick(5);
        check("done_one_pulse", start_cnt - base, 1);

        rd(0, 7);
        chk_out("rd_g0_a7", 7, 107, 207);
        tick(2);
        chk_out("rd_hold", 7, 107, 207);
        rd(5, 24);
        chk_out("rd_g5_a24", 1524, 0, 0);
        rd(0, 25);
        chk_out("rd_addr_oob", 0, 0, 0);
        rd(4, 0);
        chk_out("rd_g4_a0", 1200, 1300, 1400);

        // fill bank1 while bank0 is being consumed
        fill(1000);
        rd(0, 7);
        chk_out("pp_rd_bank0", 7, 107, 207);
        base = start_cnt;
        pulse_done();
        check("pp_wr_ready_low", wr_ready, 0);
        tick(4);
        check("pp_no_start", start_cnt - base, 0);
        pulse_end();
        check("pp_end_start_e0", start_to_next, 0);
        check("pp_end_wr_ready", wr_ready, 1);
        tick(1);
        check("pp_end_start_e1", start_to_next, 1);
        rd(1, 0);
        chk_out("pp_rd_g1_a0", 1300, 1400, 1500);

        // both banks full: writes and wr_done must be ignored
        pulse_done();
        check("blk_wr_ready", wr_ready, 0);
        wr_enable  = 1'b1;
        wr_map     = 4'd3;
        wr_address = 5'd0;
        wr_data    = 32'hDEAD;
        wr_done    = 1'b1;
        tick(1);
        wr_enable  = 1'b0;
        wr_done    = 1'b0;
        check("blk_wr_ready_after", wr_ready, 0);
        rd(1, 0);
        chk_out("blk_rd", 1300, 1400, 1500);
        base = start_cnt;
        pulse_end();
        check("blk_end_wr_ready", wr_ready, 1);
        tick(1);
        check("blk_end_start", start_to_next, 1);
        tick(3);
        check("blk_one_pulse", start_cnt - base, 1);
        rd(1, 0);
        chk_out("blk_rd_bank0", 300, 400, 500);

        // wr_done and end_from_next on the same edge
        wr_enable  = 1'b1;
        wr_map     = 4'd0;
        wr_address = 5'd0;
        wr_data    = 32'h55;
        tick(1);
        wr_enable  = 1'b0;
        base = start_cnt;
        wr_done       = 1'b1;
        end_from_next = 1'b1;
        tick(1);
        wr_done       = 1'b0;
        end_from_next = 1'b0;
        check("sim_wr_ready", wr_ready, 1);
        check("sim_start_e0", start_to_next, 0);
        tick(1);
        check("sim_start_e1", start_to_next, 1);
        tick(3);
        check("sim_one_pulse", start_cnt - base, 1);
        rd(0, 0);
        chk_out("sim_rd", 85, 1100, 1200);

        // reset while the consumer owns bank1
        ifm_enable_read  = 1'b1;
        ifm_sel          = 3'd0;
        ifm_address_read = 5'd0;
        reset            = 1'b1;
        tick(1);
        reset            = 1'b0;
        ifm_enable_read  = 1'b0;
        check("mrst_wr_ready", wr_ready, 1);
        check("mrst_start", start_to_next, 0);
        chk_out("mrst", 0, 0, 0);
        base = start_cnt;
        tick(6);
        check("mrst_no_start", start_cnt - base, 0);
        rd(0, 7);
        chk_out("mrst_mem_kept", 7, 107, 207);
        pulse_done();
        check("mrst_done_wr_ready", wr_ready, 1);
        tick(1);
        check("mrst_done_start", start_to_next, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
